// File: rtl/kmap_sweep_if.sv
// kmap_sweep_if: handshake and truth-table bus between a sweep controller and
// its host / combinational block under exercise.
//   start, abort, expected : host requests (expected = golden truth table)
//   f_in                   : function output returned by the block under exercise
//   vec                    : input vector driven to the block under exercise
//   busy, done, pass       : sweep status
//   result, err_cnt        : captured truth table and mismatch count
// Modports: slave = sweep controller, master = host plus block under exercise.
interface kmap_sweep_if #(
  parameter int N_IN = 4
);
  localparam int TBL = 1 << N_IN;

  logic             start;
  logic             abort;
  logic [TBL-1:0]   expected;
  logic [N_IN-1:0]  vec;
  logic             f_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [TBL-1:0]   result;
  logic [N_IN:0]    err_cnt;

  modport slave (
    input  start, abort, expected, f_in,
    output vec, busy, done, pass, result, err_cnt
  );

  modport master (
    output start, abort, expected, f_in,
    input  vec, busy, done, pass, result, err_cnt
  );
endinterface

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: walks a combinational N_IN-input block through all 2^N_IN
// input vectors, captures its single-bit output into a truth table and counts
// mismatches against a golden table latched at start.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : kmap_sweep_if.slave (start/abort/expected/f_in in,
//          vec/busy/done/pass/result/err_cnt out, all outputs registered)
// Parameters: N_IN (1..6) function inputs, SETTLE (>=1) hold cycles per vector.
// Optional build macro KMAP_SWEEP_GRAY_EN: visit vectors in Gray-code order so
// vec changes one bit per step; results and latency are unchanged.
module kmap_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  kmap_sweep_if.slave   bus
);

  localparam int TBL = 1 << N_IN;
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] STEP_LAST   = '1;
  localparam logic [N_IN-1:0] STEP_ONE    = 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t           state;
  logic [N_IN-1:0]  vec_q;
  logic [N_IN-1:0]  step_q;
  logic [SW-1:0]    settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [TBL-1:0]   result_q;
  logic [N_IN:0]    err_q;
  logic [TBL-1:0]   exp_q;

  logic             miss;
  logic [N_IN:0]    err_nxt;

  // Maps the sweep step to the vector actually driven.
  function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] s);
`ifdef KMAP_SWEEP_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  // Mismatch and count including the sample taken this cycle; used so that
  // pass on entry to DONE already reflects the final vector.
  always_comb begin
    miss    = bus.f_in ^ exp_q[vec_q];
    err_nxt = err_q + {{N_IN{1'b0}}, miss};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec_q    <= '0;
      step_q   <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= '0;
      err_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // start wins over a simultaneous abort here.
          if (bus.start) begin
            exp_q    <= bus.expected;
            result_q <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            step_q   <= '0;
            settle_q <= '0;
            vec_q    <= order('0);
            busy_q   <= 1'b1;
            state    <= DRIVE;
          end
        end

        DRIVE: begin
          if (bus.abort) begin
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            settle_q <= '0;
            state    <= IDLE;
          end else if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            state    <= SAMPLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        SAMPLE: begin
          // abort pre-empts the capture scheduled for this cycle.
          if (bus.abort) begin
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            state  <= IDLE;
          end else begin
            result_q[vec_q] <= bus.f_in;
            err_q           <= err_nxt;
            if (step_q == STEP_LAST) begin
              done_q <= 1'b1;
              pass_q <= (err_nxt == '0);
              state  <= DONE;
            end else begin
              step_q   <= step_q + STEP_ONE;
              vec_q    <= order(step_q + STEP_ONE);
              settle_q <= '0;
              state    <= DRIVE;
            end
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec     = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.result  = result_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// tb_kmap_sweep_ctrl: self-checking bench for kmap_sweep_ctrl. A truth table
// variable plays the combinational block; expectations come from a reference
// model built from the sweep rules (visit order, sample timing, popcount).
module tb_kmap_sweep_ctrl;

  localparam int N      = 4;
  localparam int SET    = 1;
  localparam int T      = 1 << N;
  localparam int P      = SET + 1;          // cycles per vector
  localparam int DONE_C = T * P + 1;        // cycle of the done pulse

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kmap_sweep_if #(.N_IN(N)) bus ();

  logic [T-1:0] tbl = '0;
  assign bus.f_in = tbl[bus.vec];

  kmap_sweep_ctrl #(.N_IN(N), .SETTLE(SET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  // Observations of the most recent sweep.
  logic [N-1:0] vec_at  [0:63];
  logic         busy_at [0:63];
  int           done_cycle;
  int           done_pulses;
  logic [T-1:0] res_at_done;
  logic [N:0]   err_at_done;
  logic         pass_at_done;

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] ord(input int s);
    logic [N-1:0] b = N'(s);
`ifdef KMAP_SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Outcome of a sweep cut off by abort in cycle c (c large = no abort):
  // vector at step s is sampled in cycle s*P+P+1.
  task automatic model(input logic [T-1:0] t, input logic [T-1:0] e, input int c,
                       output logic [T-1:0] res, output logic [N:0] err);
    int n = 0;
    res = '0;
    for (int s = 0; s < T; s++) begin
      if (s * P + P + 1 < c) begin
        res[ord(s)] = t[ord(s)];
        if (t[ord(s)] != e[ord(s)]) n++;
      end
    end
    err = (N+1)'(n);
  endtask

  // ---------------- stimulus driver ----------------
  // Called just after a rising edge; that cycle is cycle 0 of the sweep.
  task automatic run_sweep(input logic [T-1:0] t, input logic [T-1:0] e,
                           input logic [63:0] restart_mask, input logic [T-1:0] e_alt,
                           input int abort_cyc, input int ncyc);
    tbl          = t;
    bus.expected = e;
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    done_cycle   = -1;
    done_pulses  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.start = restart_mask[c];
      if (restart_mask[c]) bus.expected = e_alt;
      bus.abort  = (c == abort_cyc);
      vec_at[c]  = bus.vec;
      busy_at[c] = bus.busy;
      if (bus.done) begin
        done_pulses++;
        if (done_cycle < 0) begin
          done_cycle   = c;
          res_at_done  = bus.result;
          err_at_done  = bus.err_cnt;
          pass_at_done = bus.pass;
        end
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.expected = '0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    total++; if (bus.vec !== '0)     $display("FAIL reset_vec: got %h want 0", bus.vec);         else passed++;
    total++; if (bus.busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", bus.busy);       else passed++;
    total++; if (bus.done !== 1'b0)  $display("FAIL reset_done: got %b want 0", bus.done);       else passed++;
    total++; if (bus.pass !== 1'b0)  $display("FAIL reset_pass: got %b want 0", bus.pass);       else passed++;
    total++; if (bus.result !== '0)  $display("FAIL reset_result: got %h want 0", bus.result);   else passed++;
    total++; if (bus.err_cnt !== '0) $display("FAIL reset_err: got %0d want 0", bus.err_cnt);    else passed++;
    // Reset in the middle of a sweep.
    run_sweep(16'hFFFF, 16'h0000, '0, '0, -1, 10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    total++; if (bus.busy !== 1'b0)  $display("FAIL midreset_busy: got %b want 0", bus.busy);     else passed++;
    total++; if (bus.vec !== '0)     $display("FAIL midreset_vec: got %h want 0", bus.vec);       else passed++;
    total++; if (bus.result !== '0)  $display("FAIL midreset_result: got %h want 0", bus.result); else passed++;
    total++; if (bus.err_cnt !== '0) $display("FAIL midreset_err: got %0d want 0", bus.err_cnt);  else passed++;
  endtask

  task automatic test_match();
    run_sweep(16'hA5C3, 16'hA5C3, '0, '0, -1, 45);
    total++; if (done_cycle != DONE_C) $display("FAIL match_done_cycle: got %0d want %0d", done_cycle, DONE_C); else passed++;
    total++; if (done_pulses != 1)     $display("FAIL match_done_pulses: got %0d want 1", done_pulses);          else passed++;
    total++; if (res_at_done !== 16'hA5C3) $display("FAIL match_result: got %h want a5c3", res_at_done);         else passed++;
    total++; if (err_at_done !== '0)   $display("FAIL match_err: got %0d want 0", err_at_done);                  else passed++;
    total++; if (pass_at_done !== 1'b1) $display("FAIL match_pass: got %b want 1", pass_at_done);                else passed++;
    total++; if (busy_at[DONE_C] !== 1'b1) $display("FAIL match_busy_done: got %b want 1", busy_at[DONE_C]);     else passed++;
    total++; if (busy_at[DONE_C+1] !== 1'b0) $display("FAIL match_busy_after: got %b want 0", busy_at[DONE_C+1]); else passed++;
    total++; if (bus.pass !== 1'b1)    $display("FAIL match_pass_held: got %b want 1", bus.pass);                else passed++;
  endtask

  task automatic test_mismatch();
    run_sweep(16'hA5C3, 16'hA5C2, '0, '0, -1, 40);
    total++; if (res_at_done !== 16'hA5C3) $display("FAIL mis1_result: got %h want a5c3", res_at_done); else passed++;
    total++; if (err_at_done !== 5'd1) $display("FAIL mis1_err: got %0d want 1", err_at_done);          else passed++;
    total++; if (pass_at_done !== 1'b0) $display("FAIL mis1_pass: got %b want 0", pass_at_done);        else passed++;
    run_sweep(16'hA5C3, 16'h5A3C, '0, '0, -1, 40);
    total++; if (err_at_done !== 5'd16) $display("FAIL misall_err: got %0d want 16", err_at_done);      else passed++;
    total++; if (pass_at_done !== 1'b0) $display("FAIL misall_pass: got %b want 0", pass_at_done);      else passed++;
    total++; if (done_cycle != DONE_C)  $display("FAIL misall_done_cycle: got %0d want %0d", done_cycle, DONE_C); else passed++;
  endtask

  task automatic test_random();
    logic [T-1:0] t, e, mres;
    logic [N:0]   merr;
    for (int it = 0; it < 6; it++) begin
      t = T'($urandom);
      e = t;
      for (int k = 0; k < T; k++)
        if ($urandom_range(0, 3) == 0) e[k] = ~e[k];
      model(t, e, 1000, mres, merr);
      run_sweep(t, e, '0, '0, -1, 36);
      total++; if (res_at_done !== mres) $display("FAIL rand_result[%0d]: got %h want %h", it, res_at_done, mres); else passed++;
      total++; if (err_at_done !== merr) $display("FAIL rand_err[%0d]: got %0d want %0d", it, err_at_done, merr);  else passed++;
      total++; if (pass_at_done !== (merr == 0)) $display("FAIL rand_pass[%0d]: got %b want %b", it, pass_at_done, merr == 0); else passed++;
      total++; if (done_cycle != DONE_C) $display("FAIL rand_done_cycle[%0d]: got %0d want %0d", it, done_cycle, DONE_C); else passed++;
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] m = '0;
    logic [T-1:0] t = T'($urandom);
    m[3] = 1'b1; m[10] = 1'b1; m[32] = 1'b1;
    run_sweep(t, t, m, ~t, -1, 40);
    total++; if (done_pulses != 1)     $display("FAIL restart_pulses: got %0d want 1", done_pulses);                 else passed++;
    total++; if (done_cycle != DONE_C) $display("FAIL restart_done_cycle: got %0d want %0d", done_cycle, DONE_C);    else passed++;
    total++; if (err_at_done !== '0)   $display("FAIL restart_err: got %0d want 0", err_at_done);                    else passed++;
    total++; if (busy_at[DONE_C+1] !== 1'b0) $display("FAIL restart_busy_after: got %b want 0", busy_at[DONE_C+1]); else passed++;
  endtask

  task automatic test_abort_at(input int ac, input logic [T-1:0] t, input logic [T-1:0] e);
    logic [T-1:0] mres;
    logic [N:0]   merr;
    logic [N-1:0] mvec;
    model(t, e, ac, mres, merr);
    mvec = ord((ac - 1) / P);
    run_sweep(t, e, '0, '0, ac, 40);
    total++; if (done_pulses != 0)   $display("FAIL abort%0d_pulses: got %0d want 0", ac, done_pulses);        else passed++;
    total++; if (busy_at[ac+1] !== 1'b0) $display("FAIL abort%0d_busy: got %b want 0", ac, busy_at[ac+1]);     else passed++;
    total++; if (bus.result !== mres) $display("FAIL abort%0d_result: got %h want %h", ac, bus.result, mres); else passed++;
    total++; if (bus.err_cnt !== merr) $display("FAIL abort%0d_err: got %0d want %0d", ac, bus.err_cnt, merr); else passed++;
    total++; if (bus.pass !== 1'b0)  $display("FAIL abort%0d_pass: got %b want 0", ac, bus.pass);             else passed++;
    total++; if (bus.vec !== mvec)   $display("FAIL abort%0d_vec: got %h want %h", ac, bus.vec, mvec);        else passed++;
  endtask

  task automatic test_abort();
    logic [T-1:0] t;
    test_abort_at(12, 16'hA5C3, 16'h0000);
    t = T'($urandom);
    test_abort_at($urandom_range(1, DONE_C - 1), t, ~t);
    // A fresh sweep after abort completes normally.
    run_sweep(16'hA5C3, 16'hA5C3, '0, '0, -1, 36);
    total++; if (done_cycle != DONE_C) $display("FAIL post_abort_done: got %0d want %0d", done_cycle, DONE_C); else passed++;
    total++; if (pass_at_done !== 1'b1) $display("FAIL post_abort_pass: got %b want 1", pass_at_done);        else passed++;
    // Abort during DONE is ignored.
    run_sweep(16'h1234, 16'h1234, '0, '0, DONE_C, 38);
    total++; if (done_pulses != 1)     $display("FAIL abort_done_pulses: got %0d want 1", done_pulses);       else passed++;
    total++; if (bus.pass !== 1'b1)    $display("FAIL abort_done_pass: got %b want 1", bus.pass);             else passed++;
  endtask

  task automatic test_vec_order();
    int bad = 0;
    int first = -1;
    int onebit_bad = 0;
    run_sweep(16'h0F0F, 16'h0F0F, '0, '0, -1, 36);
    for (int s = 0; s < T; s++)
      if (vec_at[1 + s * P] !== ord(s)) begin
        bad++;
        if (first < 0) first = s;
      end
    total++; if (bad != 0) $display("FAIL vec_order: %0d steps wrong, first step %0d got %h want %h",
                                    bad, first, vec_at[1 + ((first < 0) ? 0 : first) * P], ord((first < 0) ? 0 : first)); else passed++;
`ifdef KMAP_SWEEP_GRAY_EN
    for (int s = 0; s < T - 1; s++)
      if ($countones(vec_at[1 + (s + 1) * P] ^ vec_at[1 + s * P]) != 1) onebit_bad++;
    total++; if (onebit_bad != 0) $display("FAIL vec_gray_onebit: got %0d bad steps want 0", onebit_bad); else passed++;
`endif
    total++; if (res_at_done !== 16'h0F0F) $display("FAIL vec_order_result: got %h want 0f0f", res_at_done); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [T-1:0] t1 = T'($urandom);
    logic [T-1:0] t2 = T'($urandom);
    logic [T-1:0] mres;
    logic [N:0]   merr;
    run_sweep(t1, t1, '0, '0, -1, DONE_C + 1);
    total++; if (pass_at_done !== 1'b1) $display("FAIL b2b_first_pass: got %b want 1", pass_at_done); else passed++;
    model(t2, t1, 1000, mres, merr);
    run_sweep(t2, t1, '0, '0, -1, 36);
    total++; if (done_cycle != DONE_C) $display("FAIL b2b_done_cycle: got %0d want %0d", done_cycle, DONE_C); else passed++;
    total++; if (res_at_done !== mres) $display("FAIL b2b_result: got %h want %h", res_at_done, mres);       else passed++;
    total++; if (err_at_done !== merr) $display("FAIL b2b_err: got %0d want %0d", err_at_done, merr);        else passed++;
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_random();
    test_start_ignored();
    test_abort();
    test_vec_order();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/kmap_sweep_ctrl.md
Name: kmap_sweep_ctrl

Overview:
Sequencer that exhaustively drives a combinational N-input truth-table block (K-map exercise circuit) through all 2^N input vectors. It samples the single-bit function output for each vector, captures it into a truth-table result register, and compares it against a caller-supplied expected pattern. The block sits between a start/done handshake (host, bench or lab-board controller) and the combinational block under exercise. It replaces ad-hoc stimulus loops with a synthesizable checker.

Parameters:
N_IN, 4, number of function inputs; vector width, table size 2^N_IN (legal 1..6)
SETTLE, 1, cycles each vector is held before sampling (legal >= 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request a sweep; honoured only in IDLE
abort  in  1  cancel a sweep in progress; return to IDLE
expected  in  2^N_IN  golden truth table, bit k = required output for vector value k; latched on accepted start
vec  out  N_IN  registered input vector driven to the combinational block; vec[N_IN-1] = a (MSB), vec[0] = d for N_IN=4
f_in  in  1  function output returned from the combinational block
busy  out  1  high from the accepted start until leaving DONE or abort
done  out  1  one-cycle pulse: sweep complete, results valid
pass  out  1  high when every captured bit matched expected; held until next accepted start
result  out  2^N_IN  captured truth table, bit k = f_in sampled while vec == k
err_cnt  out  N_IN+1  number of mismatching vectors (0..2^N_IN)

Behaviour:
- Reset (synchronous, any state) forces: state IDLE, vec=0, busy=0, done=0, pass=0, result=0, err_cnt=0, step=0, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: vec holds its last value. On start=1: latch expected, clear result/err_cnt/pass, step=0, vec=order(0), busy=1, go to DRIVE.
- DRIVE: hold vec for SETTLE cycles (counter 0..SETTLE-1), then go to SAMPLE.
- SAMPLE (one cycle): result[vec] <= f_in; if f_in != expected[vec], err_cnt += 1.
  - If step == 2^N_IN-1: go to DONE.
  - Else: step += 1, vec = order(step), go to DRIVE.
- DONE (one cycle): done=1, busy=1, pass=(err_cnt==0), with err_cnt including the final sample. Next edge: IDLE, done=0, busy=0.
- Timing: each vector costs SETTLE+1 cycles. done is high during cycle 2^N_IN*(SETTLE+1)+1, counting the cycle in which start was sampled as cycle 0. Defaults: cycle 33.
- order(step) = step (binary) unless the optional feature is enabled. result is always indexed by vector value, never by step.
- start while busy (DRIVE/SAMPLE/DONE): ignored, and expected is not re-latched.
- abort in DRIVE/SAMPLE: next edge goes to IDLE, busy=0, done never pulses, pass=0. result/err_cnt keep their partial values and vec holds.
  - abort has priority over the SAMPLE capture in the same cycle, so no capture occurs.
  - abort in IDLE or DONE: no effect, and the DONE pulse completes.
- start and abort both high in IDLE: start wins.
- Outputs are all registered. f_in is the only combinational input used and is sampled only in SAMPLE.

Optional Feature:
Macro KMAP_SWEEP_GRAY_EN.
- Defined: order(step) = step ^ (step >> 1). Vectors follow Gray/K-map adjacency, so vec changes exactly one bit per step, which minimises glitch exposure on the block under exercise.
- Undefined: plain binary order 0..2^N_IN-1.
- result, err_cnt, pass and latency are identical in both builds. Only the vec sequence differs.

Test Plan:
- Reset, then idle 5 cycles -> vec=0, busy=0, done=0, pass=0, result=16'h0000, err_cnt=0.
- f_in driven by table 16'hA5C3, expected=16'hA5C3, pulse start -> done pulse in cycle 33, result=16'hA5C3, err_cnt=0, pass=1, busy low the cycle after done.
- Same table, expected=16'hA5C2 (bit 0 wrong) -> result=16'hA5C3, err_cnt=1, pass=0. Then expected=16'h5A3C -> err_cnt=16, pass=0.
- start pulsed again in cycles 3, 10 and 32 of a sweep -> ignored: single done pulse at cycle 33, expected not re-latched.
- abort asserted in cycle 12 (SETTLE=1, a SAMPLE cycle) -> IDLE next edge, no done pulse, busy=0, result holds only vectors 0..4. A fresh start then completes normally.
- With KMAP_SWEEP_GRAY_EN: vec sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, with exactly one bit changing per step. Final result/err_cnt/pass equal the binary-order run for the same table.
